// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared SPU package: pipeline depth limit and counter sizing helper used by
// the serial packing operators and their output delay line.
package elixirchip_es1_spu_pkg;

  // Deepest output pipeline any SPU operator may request.
  localparam int SPU_LATENCY_MAX = 3;

  // Width of a counter that must represent 0..data_bits inclusive.
  function automatic int spu_count_width(input int data_bits);
    return $clog2(data_bits + 1);
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_delay.sv
// Clock-enabled valid+data delay line of LATENCY stages (0 = wire through).
// Stage count is clamped to the package limit.
module elixirchip_es1_spu_delay
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int  LATENCY = 0,
  parameter type data_t  = logic [7:0]
) (
  input  logic  reset,
  input  logic  clk,
  input  logic  cke,
  input  logic  valid_i,
  input  data_t data_i,
  output logic  valid_o,
  output data_t data_o
);

  localparam int STAGES = (LATENCY > SPU_LATENCY_MAX) ? SPU_LATENCY_MAX :
                          (LATENCY < 0)               ? 0 : LATENCY;

  if (STAGES == 0) begin : g_bypass
    assign valid_o = valid_i;
    assign data_o  = data_i;
  end else begin : g_stages
    logic [STAGES-1:0] valid_q;
    data_t             data_q [STAGES];

    // Valid shift register; reset empties the pipeline so nothing in flight survives.
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= '0;
      end else if (cke) begin
        valid_q[0] <= valid_i;
        for (int i = 1; i < STAGES; i++) valid_q[i] <= valid_q[i-1];
      end
    end

    // Data shift register, advancing in lockstep with the valid bits.
    // NOTE: data stages have no reset; their contents are ignored while the matching valid is low.
    always_ff @(posedge clk) begin
      if (cke) begin
        data_q[0] <= data_i;
        for (int i = 1; i < STAGES; i++) data_q[i] <= data_q[i-1];
      end
    end

    assign valid_o = valid_q[STAGES-1];
    assign data_o  = data_q[STAGES-1];
  end

endmodule

// File: rtl/elixirchip_es1_spu_op_pack.sv
// Serial-to-parallel packer: accepts one bit per enabled beat, LSB first, and
// emits a DATA_BITS word as a one-beat m_valid strobe LATENCY+1 beats after
// its last bit. s_clear abandons the partial word.
// Optional macro ELIXIRCHIP_ES1_SPU_OP_PACK_FLUSH_EN: s_clear emits a
// non-empty partial word (unfilled positions = CLEAR_DATA) instead of dropping it.
module elixirchip_es1_spu_op_pack
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int    LATENCY    = 0,
  parameter int    DATA_BITS  = 8,
  parameter type   data_t     = logic [DATA_BITS-1:0],
  parameter logic  CLEAR_DATA = 1'b0,
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic  reset,
  input  logic  clk,
  input  logic  cke,
  input  logic  s_data,
  input  logic  s_clear,
  input  logic  s_valid,
  output data_t m_data,
  output logic  m_valid
);

  localparam int                   CW   = spu_count_width(DATA_BITS);
  localparam logic [DATA_BITS-1:0] FILL = {DATA_BITS{CLEAR_DATA}};

  // Target/debug selectors are carried for tool flows only; no logic depends on them.
  if ((DEVICE == "") && (SIMULATION == "") && (DEBUG == "")) begin : g_no_params
  end

  logic [CW-1:0]        count_q, count_d;
  logic [DATA_BITS-1:0] word_q, word_d, word_next;
  logic                 done_valid_q, done_valid_d;
  logic [DATA_BITS-1:0] done_data_q, done_data_d;
  logic                 dly_valid;
  logic [DATA_BITS-1:0] dly_data;
  data_t                m_data_q;
  logic                 m_valid_q;
  logic                 flush_hit;

`ifdef ELIXIRCHIP_ES1_SPU_OP_PACK_FLUSH_EN
  assign flush_hit = (count_q != '0);
`else
  assign flush_hit = 1'b0;
`endif

  // Partial word with the incoming bit dropped into the slot selected by the count.
  always_comb begin
    word_next = word_q;
    for (int k = 0; k < DATA_BITS; k++) begin
      if (count_q == CW'(k)) word_next[k] = s_data;
    end
  end

  // Packing decisions: clear beats abandon (or flush) the word, accepted bits fill it.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one unassigned and no latch appears.
    count_d      = count_q;
    word_d       = word_q;
    done_valid_d = 1'b0;
    done_data_d  = done_data_q;
    if (s_clear) begin
      count_d = '0;
      word_d  = FILL;
      if (flush_hit) begin
        done_valid_d = 1'b1;
        done_data_d  = word_q;
      end
    end else if (s_valid) begin
      if (count_q == CW'(DATA_BITS - 1)) begin
        count_d      = '0;
        word_d       = FILL;
        done_valid_d = 1'b1;
        done_data_d  = word_next;
      end else begin
        count_d = count_q + CW'(1);
        word_d  = word_next;
      end
    end
  end

  // Packer state; the completed-word register gives the base one-beat latency.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      count_q      <= '0;
      word_q       <= FILL;
      done_valid_q <= 1'b0;
      done_data_q  <= FILL;
    end else if (cke) begin
      count_q      <= count_d;
      word_q       <= word_d;
      done_valid_q <= done_valid_d;
      done_data_q  <= done_data_d;
    end
  end

  elixirchip_es1_spu_delay #(
    .LATENCY (LATENCY),
    .data_t  (logic [DATA_BITS-1:0])
  ) u_delay (
    .reset   (reset),
    .clk     (clk),
    .cke     (cke),
    .valid_i (done_valid_q),
    .data_i  (done_data_q),
    .valid_o (dly_valid),
    .data_o  (dly_data)
  );

  // Output register: strobe for one beat, data held between words.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_data_q  <= data_t'(FILL);
    end else if (cke) begin
      m_valid_q <= dly_valid;
      if (dly_valid) m_data_q <= data_t'(dly_data);
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;

endmodule

// File: tb/tb_elixirchip_es1_spu_op_pack.sv
// Scoreboard bench for elixirchip_es1_spu_op_pack. Several configurations
// share one input stream; each has a bit-queue model pushing expected words
// (with due beat) and a monitor comparing m_valid/m_data every cycle.
// Configuration 0 (8 bits, latency 3) also has its word log compared with a
// hand-written list after the directed section.
module tb_elixirchip_es1_spu_op_pack;

  localparam int NCFG = 6;
  localparam int CFG_DB  [NCFG] = '{8, 1, 5, 64, 13, 3};
  localparam int CFG_LAT [NCFG] = '{3, 0, 1, 2, 0, 3};
  localparam bit CFG_CLR [NCFG] = '{0, 0, 1, 0, 1, 0};

  logic clk = 1'b0;
  logic reset, cke, s_data, s_clear, s_valid;
  bit   checking = 1'b0;
  bit   done     = 1'b0;
  int   errors   = 0;
  int   checks   = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int DB  = CFG_DB[g];
    localparam int LAT = CFG_LAT[g];
    localparam bit CLR = CFG_CLR[g];
    localparam logic [63:0] FILL = CLR ? (64'hFFFF_FFFF_FFFF_FFFF >> (64 - DB)) : 64'd0;

    typedef struct {
      logic [63:0] data;
      int          due;
    } exp_t;

    logic [DB-1:0] m_data;
    logic          m_valid;
    exp_t          exp_q[$];
    bit            bits[$];
    int            en_cnt = 0;
    logic [63:0]   last_data = FILL;

    elixirchip_es1_spu_op_pack #(
      .LATENCY    (LAT),
      .DATA_BITS  (DB),
      .CLEAR_DATA (CLR)
    ) u_dut (
      .reset   (reset),
      .clk     (clk),
      .cke     (cke),
      .s_data  (s_data),
      .s_clear (s_clear),
      .s_valid (s_valid),
      .m_data  (m_data),
      .m_valid (m_valid)
    );

    function automatic logic [63:0] word_of();
      logic [63:0] w = FILL;
      for (int k = 0; k < bits.size(); k++) w[k] = bits[k];
      return w;
    endfunction

    // Reference model: collect accepted bits, push a word when DB bits are in.
    always @(posedge clk) begin
      if (reset) begin
        bits.delete();
        exp_q.delete();
        last_data = FILL;
      end else if (cke) begin
        en_cnt++;
        if (s_clear) begin
`ifdef ELIXIRCHIP_ES1_SPU_OP_PACK_FLUSH_EN
          if (bits.size() > 0) exp_q.push_back('{word_of(), en_cnt + LAT + 1});
`endif
          bits.delete();
        end else if (s_valid) begin
          bits.push_back(s_data);
          if (bits.size() == DB) begin
            exp_q.push_back('{word_of(), en_cnt + LAT + 1});
            bits.delete();
          end
        end
      end
    end

    // Monitor: expected strobe is high exactly while the head word is due.
    always @(negedge clk) begin
      if (checking) begin
        bit exp_v;
        while (exp_q.size() > 0 && exp_q[0].due < en_cnt) void'(exp_q.pop_front());
        exp_v = (exp_q.size() > 0) && (exp_q[0].due == en_cnt);
        if (exp_v) last_data = exp_q[0].data;
        check($sformatf("cfg%0d m_valid", g), 64'(m_valid), 64'(exp_v));
        check($sformatf("cfg%0d m_data", g), 64'(m_data), last_data);
      end
    end

    initial begin
      wait (done);
      check($sformatf("cfg%0d drained", g), 64'(exp_q.size()), 64'd0);
    end
  end

  // Word log of configuration 0 for the hand-computed comparison.
  logic [7:0] got0[$];
  int         logged_cnt = -1;
  always @(negedge clk) begin
    if (checking && g_cfg[0].m_valid && g_cfg[0].en_cnt != logged_cnt) begin
      got0.push_back(g_cfg[0].m_data);
      logged_cnt = g_cfg[0].en_cnt;
    end
  end

  task automatic drive(input bit v, input bit d, input bit clr, input bit ck);
    s_valid = v;
    s_data  = d;
    s_clear = clr;
    cke     = ck;
    @(negedge clk);
  endtask

  task automatic send_word8(input logic [7:0] w);
    for (int i = 0; i < 8; i++) drive(1'b1, w[i], 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] a5;
    logic [7:0] hand[$];
    a5 = 8'hA5;
    reset = 1'b1;
    {cke, s_data, s_clear, s_valid} = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    checking = 1'b1;
    idle(2);
    reset = 1'b0;

    // A5 streamed back to back.
    send_word8(8'hA5);
    idle(8);

    // Same word with enable gaps after bits 2 and 6, then gaps around the strobe.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, a5[i], 1'b0, 1'b1);
      if (i == 1 || i == 5) drive(1'b1, ~a5[i], 1'b0, 1'b0);
    end
    idle(3);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    idle(6);

    // Clear at count 0, three bits, clear carrying a valid bit, then eight ones with a stall.
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      if (i == 3) drive(1'b0, 1'b0, 1'b0, 1'b1);
    end
    idle(8);

    // Reset while a word is in the output pipeline, then after a 5-bit partial.
    send_word8(8'h3C);
    idle(1);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    send_word8(8'h96);
    idle(8);

    hand = '{8'hA5, 8'hA5};
`ifdef ELIXIRCHIP_ES1_SPU_OP_PACK_FLUSH_EN
    hand.push_back(8'h05);
`endif
    hand.push_back(8'hFF);
    hand.push_back(8'h96);
    check("hand word count", 64'(got0.size()), 64'(hand.size()));
    for (int i = 0; i < hand.size() && i < got0.size(); i++)
      check($sformatf("hand word %0d", i), 64'(got0[i]), 64'(hand[i]));

    // Random stream with occasional clears and enable gaps.
    for (int i = 0; i < 800; i++)
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 24) == 0),
            1'($urandom_range(0, 5) != 0));
    idle(10);

    done = 1'b1;
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
